// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_pkg
//  Description : Shared encodings for the load/store unit: access sizes and
//                controller states.
//  Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    // Access size as presented on the core request interface
    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    // Controller states
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WR   = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } state_e;

endpackage : lsu_pkg
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
//  Module      : mem_lane_align
//  Description : Combinational lane handling. Extracts and extends a byte or
//                halfword from a memory word for loads, and merges store data
//                into the addressed lane of a base word for stores.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_word,   // memory word (load source / merge base)
    input  size_e       i_size,
    input  logic [1:0]  i_lane,   // byte address bits [1:0], little-endian
    input  logic        i_uns,    // 1 = zero-extend, 0 = sign-extend
    input  logic [31:0] i_wdata,  // store data, low byte/half used for sub-word
    output logic [31:0] o_load,
    output logic [31:0] o_merge
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Pick the addressed lane and extend it to a full load result
    always_comb begin
        case (i_lane)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase
        w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];
        case (i_size)
            SZ_BYTE: o_load = {{24{~i_uns & w_byte[7]}}, w_byte};
            SZ_HALF: o_load = {{16{~i_uns & w_half[15]}}, w_half};
            default: o_load = i_word;
        endcase
    end

    // Replace only the addressed lane of the base word; word stores pass through
    always_comb begin
        o_merge = i_word;
        case (i_size)
            SZ_BYTE: begin
                case (i_lane)
                    2'd0:    o_merge[7:0]   = i_wdata[7:0];
                    2'd1:    o_merge[15:8]  = i_wdata[7:0];
                    2'd2:    o_merge[23:16] = i_wdata[7:0];
                    default: o_merge[31:24] = i_wdata[7:0];
                endcase
            end
            SZ_HALF: begin
                if (i_lane[1]) o_merge[31:16] = i_wdata[15:0];
                else           o_merge[15:0]  = i_wdata[15:0];
            end
            default: o_merge = i_wdata;
        endcase
    end

endmodule : mem_lane_align
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit
//  Description : Single-outstanding load/store controller between a core and
//                a word-wide synchronous-write memory. Sub-word stores are
//                done as read-modify-write; misaligned, out-of-range and
//                illegal-size accesses are rejected with an err pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              wr,
    input  logic [1:0]        size,
    input  logic              uns,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       rdata,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_we,
    output logic [31:0]       mem_wd,
    input  logic [31:0]       mem_out
);

    state_e              r_state;
    state_e              w_state_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;
    size_e               r_size;
    logic                r_wr;
    logic                r_uns;
    logic [31:0]         r_base;
    logic [31:0]         r_rdata;

    logic                w_hi_bad;
    logic                w_reject;
    logic [31:0]         w_align_word;
    logic [31:0]         w_load;
    logic [31:0]         w_merge;

    // Address bits above the memory range must be zero; nothing to check at full width
    generate
        if (ADDR_W < 32) begin : g_hi_chk
            assign w_hi_bad = |addr[31:ADDR_W];
        end else begin : g_no_hi_chk
            assign w_hi_bad = 1'b0;
        end
    endgenerate

    assign w_reject = (size == SZ_ILL)
                    | w_hi_bad
                    | ((size == SZ_WORD) && (addr[1:0] != 2'b00))
                    | ((size == SZ_HALF) && addr[0]);

    // RD extracts from the live memory word; WR merges into the captured base
    assign w_align_word = (r_state == ST_RD) ? mem_out : r_base;

    mem_lane_align u_align (
        .i_word  (w_align_word),
        .i_size  (r_size),
        .i_lane  (r_addr[1:0]),
        .i_uns   (r_uns),
        .i_wdata (r_wdata),
        .o_load  (w_load),
        .o_merge (w_merge)
    );

    // Next-state selection
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (req) begin
                    if (w_reject)               w_state_nxt = ST_ERR;
                    else if (!wr)               w_state_nxt = ST_RD;
                    else if (size == SZ_WORD)   w_state_nxt = ST_WR;
                    else                        w_state_nxt = ST_RD;
                end
            end
            ST_RD:   w_state_nxt = r_wr ? ST_WR : ST_DONE;
            ST_WR:   w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            ST_ERR:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register, request capture, merge-base capture and load result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_wdata <= '0;
            r_size  <= SZ_BYTE;
            r_wr    <= 1'b0;
            r_uns   <= 1'b0;
            r_base  <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE && req) begin
                r_addr  <= addr[ADDR_W-1:0];
                r_wdata <= wdata;
                r_size  <= size_e'(size);
                r_wr    <= wr;
                r_uns   <= uns;
            end
            if (r_state == ST_RD) begin
                r_base <= mem_out;
                if (!r_wr) r_rdata <= w_load;
            end
        end
    end

    // Status and memory-side outputs; rst masks everything that could act on memory or the core
    assign busy   = !rst && (r_state != ST_IDLE);
    assign done   = !rst && ((r_state == ST_DONE) || (r_state == ST_ERR));
    assign err    = !rst && (r_state == ST_ERR);
    assign rdata  = r_rdata;
    assign mem_a  = (r_state == ST_IDLE) ? '0 : {r_addr[ADDR_W-1:2], 2'b00};
    assign mem_we = !rst && (r_state == ST_WR);
    assign mem_wd = (r_state == ST_WR) ? w_merge : 32'h0;

endmodule : load_store_unit
`default_nettype wire
